// File: rtl/mux_alu_src_if.sv
// ALU operand-B source bundle: register/immediate operands, forwarding inputs,
// pipeline control and the combinational/registered results.
// The master side is the datapath around the mux; the slave side is mux_alu_src.
interface mux_alu_src_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic                  ALUSrc;
    logic [1:0]            fwd_sel;
    logic [DATA_WIDTH-1:0] ex_mem_result;
    logic [DATA_WIDTH-1:0] mem_wb_result;
    logic                  valid_in;
    logic                  stall;
    logic                  flush;
    logic [DATA_WIDTH-1:0] saida;
    logic [DATA_WIDTH-1:0] saida_q;
    logic                  alusrc_q;
    logic                  valid_q;

    modport master (
        output rd2, imm, ALUSrc, fwd_sel, ex_mem_result, mem_wb_result,
               valid_in, stall, flush,
        input  saida, saida_q, alusrc_q, valid_q
    );

    modport slave (
        input  rd2, imm, ALUSrc, fwd_sel, ex_mem_result, mem_wb_result,
               valid_in, stall, flush,
        output saida, saida_q, alusrc_q, valid_q
    );
endinterface

// File: rtl/mux_alu_src.sv
// ALU operand-B source select for the RV32I datapath.
// saida is a zero-latency combinational pick of imm or the register operand;
// saida_q/alusrc_q/valid_q are the EX-stage registered copies with stall/flush.
// Optional feature macro: MUX_ALU_SRC_FWD_EN
//   defined   -> fwd_sel chooses rd2 / ex_mem_result / mem_wb_result
//   undefined -> register operand is always rd2 (forwarding ports ignored)
module mux_alu_src #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_alu_src_if.slave  bus
);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    logic [DATA_WIDTH-1:0] reg_op;
    logic [DATA_WIDTH-1:0] sel_op;
    logic [DATA_WIDTH-1:0] saida_r;
    logic                  alusrc_r;
    logic                  valid_r;

`ifdef MUX_ALU_SRC_FWD_EN
    // Forwarding decode for the register operand; the reserved code falls back to rd2.
    always_comb begin
        reg_op = bus.rd2;
        case (bus.fwd_sel)
            FWD_RF:    reg_op = bus.rd2;
            FWD_EXMEM: reg_op = bus.ex_mem_result;
            FWD_MEMWB: reg_op = bus.mem_wb_result;
            default:   reg_op = bus.rd2;
        endcase
    end
`else
    // Forwarding disabled: the register operand is always the register-file read.
    always_comb begin
        reg_op = bus.rd2;
    end

    logic unused_fwd;
    assign unused_fwd = ^{FWD_RF, FWD_EXMEM, FWD_MEMWB, bus.fwd_sel,
                          bus.ex_mem_result, bus.mem_wb_result};
`endif

    // Operand-B select: immediate or register operand, full-width pass-through.
    always_comb begin
        sel_op = reg_op;
        if (bus.ALUSrc) begin
            sel_op = bus.imm;
        end
    end

    assign bus.saida = sel_op;

    // EX-stage register: flush wins over stall; otherwise capture regardless of valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_r  <= '0;
            alusrc_r <= 1'b0;
            valid_r  <= 1'b0;
        end else if (bus.flush) begin
            saida_r  <= '0;
            alusrc_r <= 1'b0;
            valid_r  <= 1'b0;
        end else if (!bus.stall) begin
            saida_r  <= sel_op;
            alusrc_r <= bus.ALUSrc;
            valid_r  <= bus.valid_in;
        end
    end

    assign bus.saida_q  = saida_r;
    assign bus.alusrc_q = alusrc_r;
    assign bus.valid_q  = valid_r;

endmodule

// File: tb/tb_mux_alu_src.sv
// Directed bench for mux_alu_src: combinational select, forwarding decode
// (expectations follow MUX_ALU_SRC_FWD_EN), registered stage, stall/flush, reset.
module tb_mux_alu_src;

    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mux_alu_src_if #(.DATA_WIDTH(DW)) bus ();

    mux_alu_src #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [DW-1:0] exp_fwd1;
        logic [DW-1:0] exp_fwd2;
        checks   = 0;
        failures = 0;

`ifdef MUX_ALU_SRC_FWD_EN
        exp_fwd1 = 32'd7;
        exp_fwd2 = 32'd9;
`else
        exp_fwd1 = 32'd1;
        exp_fwd2 = 32'd1;
`endif

        rst_n             = 1'b0;
        bus.rd2           = '0;
        bus.imm           = '0;
        bus.ALUSrc        = 1'b0;
        bus.fwd_sel       = 2'b00;
        bus.ex_mem_result = '0;
        bus.mem_wb_result = '0;
        bus.valid_in      = 1'b0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;

        #2;
        check_eq("rst_saida_q", bus.saida_q, 32'd0);
        check_eq("rst_alusrc_q", {31'd0, bus.alusrc_q}, 32'd0);
        check_eq("rst_valid_q", {31'd0, bus.valid_q}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // combinational select
        bus.rd2 = 32'd1; bus.imm = 32'd11111; bus.ALUSrc = 1'b1; bus.fwd_sel = 2'b00;
        #5 check_eq("comb_imm", bus.saida, 32'd11111);
        bus.ALUSrc = 1'b0;
        #5 check_eq("comb_rd2", bus.saida, 32'd1);

        // forwarding decode
        bus.ex_mem_result = 32'd7; bus.mem_wb_result = 32'd9;
        bus.fwd_sel = 2'b01;
        #1 check_eq("fwd_01", bus.saida, exp_fwd1);
        bus.fwd_sel = 2'b10;
        #1 check_eq("fwd_10", bus.saida, exp_fwd2);
        bus.fwd_sel = 2'b11;
        #1 check_eq("fwd_11", bus.saida, 32'd1);
        bus.imm = 32'd5; bus.ALUSrc = 1'b1;
        #1 check_eq("fwd_imm_over", bus.saida, 32'd5);
        bus.imm = 32'h8000_0001;
        #1 check_eq("comb_fullwidth", bus.saida, 32'h8000_0001);
        bus.fwd_sel = 2'b00;

        // registered stage
        @(negedge clk);
        bus.imm = 32'hDEAD_BEEF; bus.ALUSrc = 1'b1; bus.valid_in = 1'b1;
        edge_sample();
        check_eq("reg_saida_q", bus.saida_q, 32'hDEAD_BEEF);
        check_eq("reg_alusrc_q", {31'd0, bus.alusrc_q}, 32'd1);
        check_eq("reg_valid_q", {31'd0, bus.valid_q}, 32'd1);

        bus.stall = 1'b1; bus.rd2 = 32'd3; bus.ALUSrc = 1'b0;
        edge_sample();
        edge_sample();
        check_eq("stall_saida_q", bus.saida_q, 32'hDEAD_BEEF);
        check_eq("stall_alusrc_q", {31'd0, bus.alusrc_q}, 32'd1);
        check_eq("stall_valid_q", {31'd0, bus.valid_q}, 32'd1);

        bus.stall = 1'b0;
        edge_sample();
        check_eq("unstall_saida_q", bus.saida_q, 32'd3);
        check_eq("unstall_alusrc_q", {31'd0, bus.alusrc_q}, 32'd0);

        bus.valid_in = 1'b0; bus.imm = 32'h55; bus.ALUSrc = 1'b1;
        edge_sample();
        check_eq("novalid_saida_q", bus.saida_q, 32'h55);
        check_eq("novalid_valid_q", {31'd0, bus.valid_q}, 32'd0);

        bus.valid_in = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
        edge_sample();
        check_eq("flush_saida_q", bus.saida_q, 32'd0);
        check_eq("flush_alusrc_q", {31'd0, bus.alusrc_q}, 32'd0);
        check_eq("flush_valid_q", {31'd0, bus.valid_q}, 32'd0);

        // async reset with a loaded value, asserted mid-stall
        bus.flush = 1'b0; bus.stall = 1'b0; bus.imm = 32'h1234; bus.ALUSrc = 1'b1;
        edge_sample();
        check_eq("load_saida_q", bus.saida_q, 32'h1234);
        bus.stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_saida_q", bus.saida_q, 32'd0);
        check_eq("arst_valid_q", {31'd0, bus.valid_q}, 32'd0);
        check_eq("arst_alusrc_q", {31'd0, bus.alusrc_q}, 32'd0);
        check_eq("arst_saida", bus.saida, 32'h1234);
        @(negedge clk);
        rst_n = 1'b1;
        edge_sample();
        check_eq("post_rst_stall", bus.saida_q, 32'd0);
        bus.stall = 1'b0;
        edge_sample();
        check_eq("post_rst_load", bus.saida_q, 32'h1234);
        check_eq("post_rst_valid", {31'd0, bus.valid_q}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
